// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode seven-segment scanner for the stopwatch.
// Snapshots the packed BCD value once per frame, then time-multiplexes the four
// digits with leading-zero blanking, a colon indicator on one decimal point,
// a dash for invalid BCD nibbles and per-slot PWM brightness.
// All display outputs are registered and default to dark.
module seven_seg_scan #(
    parameter int DIGIT_PERIOD  = 100000,
    parameter bit BLANK_LEADING = 1'b1,
    parameter int DP_DIGIT      = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] numbers,
    input  logic        enable,
    input  logic        colon,
    input  logic [2:0]  bright,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // DIGIT_PERIOD is at least 8, so the counter is always at least 3 bits wide.
    localparam int CNT_W = $clog2(DIGIT_PERIOD);

    // One eighth of a slot is the PWM brightness step.
    localparam int SLICE = DIGIT_PERIOD / 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W:0]   SLICE_W  = (CNT_W + 1)'(SLICE);
    localparam logic [1:0]       DP_IDX   = 2'(DP_DIGIT);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;

    logic             cnt_wrap;
    logic             frame_end;
    logic [3:0]       digit;
    logic             blank;
    logic [CNT_W:0]   on_limit;
    logic             on;
    logic             lit;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    // Slot timing, current digit selection, blanking and PWM window.
    always_comb begin
        cnt_wrap  = (cnt == CNT_LAST);
        frame_end = cnt_wrap && (idx == 2'd3);
        digit     = shadow[{idx, 2'b00} +: 4];

        // A digit is a leading zero when it and every digit to its left are zero.
        blank = 1'b0;
        if (BLANK_LEADING) begin
            case (idx)
                2'd3:    blank = (shadow[15:12] == 4'h0);
                2'd2:    blank = (shadow[15:8]  == 8'h00);
                2'd1:    blank = (shadow[15:4]  == 12'h000);
                default: blank = 1'b0;
            endcase
        end

        // bright=7 gives SLICE*8 = DIGIT_PERIOD, so the digit is on all slot.
        on_limit = SLICE_W * ({{(CNT_W - 2){1'b0}}, bright} + {{CNT_W{1'b0}}, 1'b1});
        on       = ({1'b0, cnt} < on_limit);
        lit      = enable && on && !blank;
    end

    // Slot counter: runs 0..DIGIT_PERIOD-1 and wraps.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index advances 0,1,2,3,0 each time the slot counter wraps.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (cnt_wrap) begin
            idx <= idx + 2'd1;
        end
    end

    // Snapshot the input on the last cycle of a frame so a frame never mixes values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            shadow <= 16'h0000;
        end else if (frame_end) begin
            shadow <= numbers;
        end
    end

    // Registered display drive; old and new anodes change in the same update.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (lit) begin
            an  <= ~(4'b0001 << idx);
            seg <= decode(digit);
            dp  <= ~(colon && (idx == DP_IDX));
        end else begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized and directed stimulus for seven_seg_scan with
// DIGIT_PERIOD=8, comparing both a blanking and a non-blanking instance
// against a cycle-indexed reference model of the display.
module tb_seven_seg_scan;

    localparam int P        = 8;
    localparam int HIST_MAX = 4096;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] numbers;
    logic        enable;
    logic        colon;
    logic [2:0]  bright;

    logic [3:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;
    logic        dp_b, dp_n;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    logic [15:0] num_hist [HIST_MAX];

    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    seven_seg_scan #(.DIGIT_PERIOD(P), .BLANK_LEADING(1'b1), .DP_DIGIT(2)) dut_b (
        .CLK(CLK), .reset(reset), .numbers(numbers), .enable(enable),
        .colon(colon), .bright(bright), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    seven_seg_scan #(.DIGIT_PERIOD(P), .BLANK_LEADING(1'b0), .DP_DIGIT(2)) dut_n (
        .CLK(CLK), .reset(reset), .numbers(numbers), .enable(enable),
        .colon(colon), .bright(bright), .an(an_n), .seg(seg_n), .dp(dp_n)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got=%h expected=%h", tag, t, got, want);
        end
    endtask

    // Expected display for the tc-th clock edge after reset release.
    function automatic void model(input int tc, input bit blank_lead,
                                  output logic [3:0] e_an, output logic [6:0] e_seg,
                                  output logic e_dp);
        int          slot_cnt;
        int          slot_idx;
        int          frame;
        int          digit;
        logic [15:0] sh;
        logic [15:0] upper;
        bit          blank;
        bit          on;
        slot_cnt = tc % P;
        slot_idx = (tc / P) % 4;
        frame    = tc / (4 * P);
        sh       = (frame == 0) ? 16'h0000 : num_hist[frame * 4 * P - 1];
        upper    = sh >> (4 * slot_idx);
        digit    = int'(upper & 16'h000F);
        blank    = blank_lead && (slot_idx != 0) && (upper == 16'h0000);
        on       = slot_cnt < (P / 8) * (int'(bright) + 1);
        e_an     = 4'b1111;
        e_seg    = 7'b1111111;
        e_dp     = 1'b1;
        if (enable && on && !blank) begin
            e_an  = ~(4'b0001 << slot_idx);
            e_seg = seg_table[digit];
            e_dp  = !(colon && slot_idx == 2);
        end
    endfunction

    function automatic logic [15:0] rand_bcdish();
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Drive inputs at the falling edge, then check both instances after the next rising edge.
    task automatic applyStimulus(input int n, input bit rnd, input logic [15:0] nums,
                                 input logic en, input logic col, input logic [2:0] br);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (!rnd) begin
            numbers = nums;
            enable  = en;
            colon   = col;
            bright  = br;
        end
        for (int i = 0; i < n; i++) begin
            if (t >= HIST_MAX) begin
                checkOutput("hist_bound", 32'(t), 32'(HIST_MAX - 1));
                return;
            end
            if (rnd) begin
                if ($urandom_range(0, 7) == 0) numbers = rand_bcdish();
                if ($urandom_range(0, 3) == 0) enable  = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 3) == 0) colon   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) bright  = 3'($urandom_range(0, 7));
            end
            num_hist[t] = numbers;
            @(posedge CLK);
            @(negedge CLK);
            model(t, 1'b1, e_an, e_seg, e_dp);
            checkOutput("an_blank", 32'(an_b), 32'(e_an));
            checkOutput("seg_blank", 32'(seg_b), 32'(e_seg));
            checkOutput("dp_blank", 32'(dp_b), 32'(e_dp));
            model(t, 1'b0, e_an, e_seg, e_dp);
            checkOutput("an_noblank", 32'(an_n), 32'(e_an));
            checkOutput("seg_noblank", 32'(seg_n), 32'(e_seg));
            checkOutput("dp_noblank", 32'(dp_n), 32'(e_dp));
            t++;
        end
    endtask

    // Assert reset at a falling edge and expect every output dark before any clock edge.
    task automatic reset_dut();
        reset = 1'b1;
        #1;
        checkOutput("rst_async_an", 32'(an_b), 32'hF);
        checkOutput("rst_async_seg", 32'(seg_b), 32'h7F);
        checkOutput("rst_async_dp", 32'(dp_b), 32'h1);
        checkOutput("rst_async_an_n", 32'(an_n), 32'hF);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_hold_an", 32'(an_n), 32'hF);
        checkOutput("rst_hold_seg", 32'(seg_n), 32'h7F);
        checkOutput("rst_hold_dp", 32'(dp_n), 32'h1);
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        reset   = 1'b1;
        numbers = 16'h0000;
        enable  = 1'b1;
        colon   = 1'b0;
        bright  = 3'd7;
        @(negedge CLK);
        reset_dut();

        // First frame after reset shows 0000, then 1234; reset again mid-slot.
        applyStimulus(96, 1'b0, 16'h1234, 1'b1, 1'b0, 3'd7);
        applyStimulus(13, 1'b0, 16'h1234, 1'b1, 1'b1, 3'd7);
        reset_dut();

        // Switch value during idx=1 of a frame; the change must wait for the frame boundary.
        applyStimulus(42, 1'b0, 16'h1234, 1'b1, 1'b0, 3'd7);
        applyStimulus(96, 1'b0, 16'h5678, 1'b1, 1'b0, 3'd7);

        // Leading-zero blanking and the invalid-nibble dash with the colon lit.
        applyStimulus(64, 1'b0, 16'h0005, 1'b1, 1'b0, 3'd7);
        applyStimulus(64, 1'b0, 16'h0105, 1'b1, 1'b0, 3'd7);
        applyStimulus(64, 1'b0, 16'h00A0, 1'b1, 1'b1, 3'd7);
        applyStimulus(64, 1'b0, 16'h90F0, 1'b1, 1'b1, 3'd7);

        // Brightness windows and a dark display with scanning continuing.
        applyStimulus(64, 1'b0, 16'h4321, 1'b1, 1'b1, 3'd1);
        applyStimulus(64, 1'b0, 16'h4321, 1'b1, 1'b1, 3'd0);
        applyStimulus(64, 1'b0, 16'h4321, 1'b0, 1'b1, 3'd7);
        applyStimulus(64, 1'b0, 16'h4321, 1'b1, 1'b1, 3'd4);

        // Long randomized run from a fresh reset.
        reset_dut();
        applyStimulus(3000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
